// File: rtl/cpu_state_dumper_pkg.sv
// Shared types for the CPU state dumper: FSM states and payload source codes.
package cpu_state_dumper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REG   = 2'd1,
        MEM   = 2'd2,
        DRAIN = 2'd3
    } dump_state_t;

    localparam logic SRC_REG = 1'b0;
    localparam logic SRC_MEM = 1'b1;

endpackage

// File: rtl/cpu_state_dumper_dump_out_stage.sv
// Single-entry valid/ready output register. A load overwrites the entry and
// raises valid; an accepted entry with no new load drops valid.
module dump_out_stage #(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              src_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              last_i,
    input  logic              ready_i,
    output logic              can_load_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic              src_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              last_o
);

    // The entry is free when empty or being drained this cycle.
    assign can_load_o = !valid_o || ready_i;

    // Capture a new beat, hold while stalled, empty once accepted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            data_o  <= '0;
            src_o   <= 1'b0;
            idx_o   <= '0;
            last_o  <= 1'b0;
        end else if (load_i) begin
            valid_o <= 1'b1;
            data_o  <= data_i;
            src_o   <= src_i;
            idx_o   <= idx_i;
            last_o  <= last_i;
        end else if (ready_i) begin
            valid_o <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_state_dumper.sv
// Debug engine that snapshots the register file then data memory and streams
// one word per beat over valid/ready, optionally freezing the CPU meanwhile.
module cpu_state_dumper
    import cpu_state_dumper_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_MEM    = 32,
    parameter int IDX_W      = 8,
    parameter int TRIG_CYCLE = 30,
    parameter int CNT_W      = 16,
    parameter int FREEZE_EN  = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    output logic [IDX_W-1:0]  rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [IDX_W-1:0]  mem_addr_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DATA_W-1:0] dump_data_o,
    output logic              dump_src_o,
    output logic [IDX_W-1:0]  dump_idx_o,
    output logic              dump_last_o,
    output logic              busy_o,
    output logic              freeze_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);

    localparam bit              HAS_MEM   = (NUM_MEM != 0);
    localparam bit              AUTO_EN   = (TRIG_CYCLE != 0);
    localparam int              TRIG_M1_I = AUTO_EN ? TRIG_CYCLE - 1 : 0;
    localparam int              MEM_END_I = HAS_MEM ? NUM_MEM - 1 : 0;
    localparam logic [CNT_W-1:0] TRIG_M1  = CNT_W'(TRIG_M1_I);
    localparam logic [IDX_W-1:0] REG_END  = IDX_W'(NUM_REGS - 1);
    localparam logic [IDX_W-1:0] MEM_END  = IDX_W'(MEM_END_I);

    dump_state_t       state;
    logic [IDX_W-1:0]  idx;
    logic              armed;
    logic              auto_hit;
    logic              trig;
    logic              in_reg;
    logic              in_mem;
    logic              can_load;
    logic              load;
    logic              at_end;
    logic              ld_last;
    logic              ld_src;
    logic [DATA_W-1:0] ld_data;

    // The auto-trigger fires on the TRIG_CYCLE-th edge after reset, once.
    assign auto_hit = AUTO_EN && armed && (cycle_cnt_o == TRIG_M1);
    assign trig     = start_i || auto_hit;

    assign in_reg   = (state == REG);
    assign in_mem   = (state == MEM);
    assign load     = (in_reg || in_mem) && can_load;
    assign at_end   = in_mem ? (idx == MEM_END) : (idx == REG_END);
    assign ld_last  = in_mem ? at_end : (at_end && !HAS_MEM);
    assign ld_src   = in_mem ? SRC_MEM : SRC_REG;
    assign ld_data  = in_mem ? mem_data_i : rf_data_i;
    assign freeze_o = (FREEZE_EN != 0) && busy_o;

    // Saturating cycle counter and one-shot auto-trigger arming.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_cnt_o <= '0;
            armed       <= 1'b1;
        end else begin
            if (cycle_cnt_o != {CNT_W{1'b1}})
                cycle_cnt_o <= cycle_cnt_o + 1'b1;
            if (auto_hit)
                armed <= 1'b0;
        end
    end

    // Snapshot sequencer: walks RF then DM indices, one load per free slot.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            idx        <= '0;
            rf_addr_o  <= '0;
            mem_addr_o <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (trig) begin
                        state     <= REG;
                        idx       <= '0;
                        rf_addr_o <= '0;
                        busy_o    <= 1'b1;
                    end
                end
                REG: begin
                    if (load) begin
                        if (at_end) begin
                            state     <= HAS_MEM ? MEM : DRAIN;
                            idx       <= '0;
                            rf_addr_o <= '0;
                        end else begin
                            idx       <= idx + 1'b1;
                            rf_addr_o <= idx + 1'b1;
                        end
                    end
                end
                MEM: begin
                    if (load) begin
                        if (at_end) begin
                            state      <= DRAIN;
                            idx        <= '0;
                            mem_addr_o <= '0;
                        end else begin
                            idx        <= idx + 1'b1;
                            mem_addr_o <= idx + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (dump_valid_o && dump_ready_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dump_out_stage #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_out (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .data_i     (ld_data),
        .src_i      (ld_src),
        .idx_i      (idx),
        .last_i     (ld_last),
        .ready_i    (dump_ready_i),
        .can_load_o (can_load),
        .valid_o    (dump_valid_o),
        .data_o     (dump_data_o),
        .src_o      (dump_src_o),
        .idx_o      (dump_idx_o),
        .last_o     (dump_last_o)
    );

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Bench for cpu_state_dumper: a default instance and a small RF-only instance
// with freeze disabled, checked against a beat-list model of the snapshot.
module tb_cpu_state_dumper;

    localparam int DW = 32;
    localparam int IW = 8;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, ready0, start1, ready1;
    logic [IW-1:0] rf_addr0, mem_addr0, idx0, rf_addr1, mem_addr1, idx1;
    logic [DW-1:0] rf_data0, mem_data0, data0, rf_data1, mem_data1, data1;
    logic valid0, src0, last0, busy0, freeze0, done0;
    logic valid1, src1, last1, busy1, freeze1, done1;
    logic [CW-1:0] cnt0, cnt1;

    logic [DW-1:0] rf0 [32];
    logic [DW-1:0] dm0 [32];
    logic [DW-1:0] rf1 [4];

    assign rf_data0  = rf0[rf_addr0[4:0]];
    assign mem_data0 = dm0[mem_addr0[4:0]];
    assign rf_data1  = rf1[rf_addr1[1:0]];
    assign mem_data1 = 32'hDEAD_BEEF;

    cpu_state_dumper dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0),
        .rf_addr_o(rf_addr0), .rf_data_i(rf_data0),
        .mem_addr_o(mem_addr0), .mem_data_i(mem_data0),
        .dump_valid_o(valid0), .dump_ready_i(ready0), .dump_data_o(data0),
        .dump_src_o(src0), .dump_idx_o(idx0), .dump_last_o(last0),
        .busy_o(busy0), .freeze_o(freeze0), .done_o(done0), .cycle_cnt_o(cnt0)
    );

    cpu_state_dumper #(
        .NUM_REGS(4), .NUM_MEM(0), .TRIG_CYCLE(0), .FREEZE_EN(0)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1),
        .rf_addr_o(rf_addr1), .rf_data_i(rf_data1),
        .mem_addr_o(mem_addr1), .mem_data_i(mem_data1),
        .dump_valid_o(valid1), .dump_ready_i(ready1), .dump_data_o(data1),
        .dump_src_o(src1), .dump_idx_o(idx1), .dump_last_o(last1),
        .busy_o(busy1), .freeze_o(freeze1), .done_o(done1), .cycle_cnt_o(cnt1)
    );

    typedef struct packed {
        logic          src;
        logic [IW-1:0] idx;
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    beat_t exp_q[$];
    beat_t got_q[$];
    int    got_cyc[$];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
        got_q.delete();
        got_cyc.delete();
    endtask

    // Expected snapshot: every register in order, then every memory word.
    function automatic void build_model(input int nr, input int nm, input int which);
        beat_t b;
        exp_q.delete();
        for (int i = 0; i < nr; i++) begin
            b.src  = 1'b0;
            b.idx  = IW'(i);
            b.data = (which == 0) ? rf0[i] : rf1[i];
            b.last = (nm == 0) && (i == nr - 1);
            exp_q.push_back(b);
        end
        for (int i = 0; i < nm; i++) begin
            b.src  = 1'b1;
            b.idx  = IW'(i);
            b.data = dm0[i];
            b.last = (i == nm - 1);
            exp_q.push_back(b);
        end
    endfunction

    function automatic beat_t cur0();
        return {src0, idx0, data0, last0};
    endfunction

    function automatic beat_t cur1();
        return {src1, idx1, data1, last1};
    endfunction

    task automatic test_reset();
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
        tick();
        total++;
        if ({valid0, src0, last0, busy0, freeze0, done0} !== 6'b0) begin
            bad++; $display("FAIL reset_ctl0: got %b want 000000", {valid0, src0, last0, busy0, freeze0, done0});
        end
        total++;
        if (data0 !== '0 || idx0 !== '0) begin
            bad++; $display("FAIL reset_payload0: data=%h idx=%0d want 0/0", data0, idx0);
        end
        total++;
        if (cnt0 !== '0) begin
            bad++; $display("FAIL reset_cnt0: got %0d want 0", cnt0);
        end
        total++;
        if (rf_addr0 !== '0 || mem_addr0 !== '0) begin
            bad++; $display("FAIL reset_addr0: rf=%0d mem=%0d want 0/0", rf_addr0, mem_addr0);
        end
        total++;
        if ({valid1, busy1, freeze1, done1} !== 4'b0 || cnt1 !== '0 || data1 !== '0) begin
            bad++; $display("FAIL reset_dut1: ctl=%b cnt=%0d data=%h want zeros", {valid1, busy1, freeze1, done1}, cnt1, data1);
        end
    endtask

    task automatic test_auto_dump();
        int dones;
        int done_at;
        int errs;
        for (int i = 0; i < 32; i++) begin
            rf0[i] = 32'(i * 3);
            dm0[i] = 32'(100 + i);
        end
        build_model(32, 32, 0);
        ready0 = 1'b1; ready1 = 1'b1;
        do_reset();
        dones = 0; done_at = -1; errs = 0;
        for (int k = 0; k < 130; k++) begin
            tick();
            if (valid0 && ready0) begin
                got_q.push_back(cur0());
                got_cyc.push_back(cyc);
            end
            if (done0) begin
                dones++; done_at = cyc;
            end
        end
        total++;
        if (got_q.size() != 64) begin
            bad++; $display("FAIL auto_count: got %0d want 64", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL auto_beat%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
        if (got_q.size() == 64) begin
            total++;
            if (got_cyc[0] != 31) begin
                bad++; $display("FAIL auto_first_cycle: got %0d want 31", got_cyc[0]);
            end
            total++;
            if (got_cyc[63] != 94 || got_q[63].last !== 1'b1) begin
                bad++; $display("FAIL auto_last_beat: cycle %0d last %b want 94/1", got_cyc[63], got_q[63].last);
            end
        end
        total++;
        if (dones != 1 || done_at != 95) begin
            bad++; $display("FAIL auto_done: count %0d at %0d want 1 at 95", dones, done_at);
        end
        total++;
        if (busy0 !== 1'b0) begin
            bad++; $display("FAIL auto_idle_after: busy %b want 0", busy0);
        end
    endtask

    task automatic test_backpressure();
        beat_t prev;
        bit    prev_stall;
        int    dones;
        int    stalls;
        for (int i = 0; i < 32; i++) begin
            rf0[i] = $urandom();
            dm0[i] = $urandom();
        end
        build_model(32, 32, 0);
        ready0 = 1'b0;
        do_reset();
        prev_stall = 1'b0; dones = 0; stalls = 0; prev = '0;
        for (int k = 0; k < 600; k++) begin
            tick();
            if (prev_stall) begin
                stalls++;
                total++;
                if (valid0 !== 1'b1 || cur0() !== prev) begin
                    bad++; $display("FAIL bp_hold cyc%0d: got v=%b %h want v=1 %h", cyc, valid0, cur0(), prev);
                end
            end
            ready0 = 1'($urandom_range(0, 1));
            if (valid0 && ready0) got_q.push_back(cur0());
            if (done0) dones++;
            prev_stall = valid0 && !ready0;
            prev = cur0();
        end
        total++;
        if (got_q.size() != 64) begin
            bad++; $display("FAIL bp_count: got %0d want 64", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL bp_beat%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
        total++;
        if (dones != 1) begin
            bad++; $display("FAIL bp_done: count %0d want 1 (timeout if 0)", dones);
        end
        total++;
        if (stalls == 0) begin
            bad++; $display("FAIL bp_stalls: got %0d stalled cycles want >0", stalls);
        end
        ready0 = 1'b1;
    endtask

    task automatic test_small_manual();
        int dones;
        int done_at;
        int mem_act;
        for (int i = 0; i < 4; i++) rf1[i] = $urandom();
        build_model(4, 0, 1);
        ready0 = 1'b1; ready1 = 1'b1;
        do_reset();
        dones = 0; done_at = -1; mem_act = 0;
        for (int k = 0; k < 40; k++) begin
            start1 = (cyc == 4);
            tick();
            if (mem_addr1 !== '0) mem_act++;
            if (valid1 && ready1) begin
                got_q.push_back(cur1());
                got_cyc.push_back(cyc);
            end
            if (done1) begin
                dones++; done_at = cyc;
            end
        end
        start1 = 1'b0;
        total++;
        if (got_q.size() != 4) begin
            bad++; $display("FAIL small_count: got %0d want 4", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL small_beat%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
        if (got_cyc.size() > 0) begin
            total++;
            if (got_cyc[0] != 6) begin
                bad++; $display("FAIL small_first_cycle: got %0d want 6", got_cyc[0]);
            end
        end
        total++;
        if (dones != 1 || done_at != 10) begin
            bad++; $display("FAIL small_done: count %0d at %0d want 1 at 10", dones, done_at);
        end
        total++;
        if (mem_act != 0) begin
            bad++; $display("FAIL small_mem_addr: %0d active cycles want 0", mem_act);
        end
    endtask

    task automatic test_dropped_triggers();
        int  dones;
        int  done_at;
        int  busy_after;
        bit  seen_done;
        build_model(32, 32, 0);
        ready0 = 1'b1;
        do_reset();
        dones = 0; done_at = -1; busy_after = 0; seen_done = 1'b0;
        for (int k = 0; k < 200; k++) begin
            start0 = (cyc == 2) || (cyc == 29) || (cyc == 40);
            tick();
            if (valid0 && ready0) begin
                got_q.push_back(cur0());
                got_cyc.push_back(cyc);
            end
            if (done0) begin
                dones++; done_at = cyc; seen_done = 1'b1;
            end
            if (seen_done && busy0) busy_after++;
        end
        start0 = 1'b0;
        total++;
        if (got_q.size() != 64) begin
            bad++; $display("FAIL drop_count: got %0d want 64", got_q.size());
        end
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
            total++;
            if (got_q[k] !== exp_q[k]) begin
                bad++; $display("FAIL drop_beat%0d: got %h want %h", k, got_q[k], exp_q[k]);
            end
        end
        if (got_cyc.size() > 0) begin
            total++;
            if (got_cyc[0] != 4) begin
                bad++; $display("FAIL drop_first_cycle: got %0d want 4", got_cyc[0]);
            end
        end
        total++;
        if (dones != 1 || done_at != 68) begin
            bad++; $display("FAIL drop_done: count %0d at %0d want 1 at 68", dones, done_at);
        end
        total++;
        if (busy_after != 0) begin
            bad++; $display("FAIL drop_busy_after: %0d busy cycles after done want 0", busy_after);
        end
    endtask

    task automatic test_reset_mid_dump();
        bit found;
        int first_v;
        int dones;
        ready0 = 1'b1;
        do_reset();
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            tick();
            if (valid0 && src0 == 1'b0 && idx0 == 8'd10) found = 1'b1;
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL midrst_reach: beat 10 seen=%b want 1 (timeout)", found);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({valid0, src0, last0, busy0, freeze0, done0} !== 6'b0 || data0 !== '0 || idx0 !== '0) begin
            bad++; $display("FAIL midrst_outputs: ctl=%b data=%h idx=%0d want zeros", {valid0, src0, last0, busy0, freeze0, done0}, data0, idx0);
        end
        total++;
        if (cnt0 !== '0 || rf_addr0 !== '0 || mem_addr0 !== '0) begin
            bad++; $display("FAIL midrst_cnt_addr: cnt=%0d rf=%0d mem=%0d want 0", cnt0, rf_addr0, mem_addr0);
        end
        rst = 1'b0;
        cyc = 0;
        tick();
        total++;
        if (cnt0 !== 16'd1) begin
            bad++; $display("FAIL midrst_cnt_restart: got %0d want 1", cnt0);
        end
        first_v = -1; dones = 0;
        for (int k = 0; k < 60; k++) begin
            if (valid0 && first_v < 0) begin
                first_v = cyc;
                total++;
                if (idx0 !== '0 || src0 !== 1'b0) begin
                    bad++; $display("FAIL midrst_first_beat: src=%b idx=%0d want 0/0", src0, idx0);
                end
            end
            if (done0) dones++;
            tick();
        end
        total++;
        if (first_v != 31) begin
            bad++; $display("FAIL midrst_retrigger: first valid at %0d want 31", first_v);
        end
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL midrst_no_done: got %0d done pulses want 0", dones);
        end
    endtask

    task automatic test_freeze();
        bit saw0;
        bit saw1;
        do_reset();
        saw0 = 1'b0; saw1 = 1'b0;
        for (int k = 0; k < 150; k++) begin
            start1 = (cyc == 2);
            tick();
            ready0 = 1'($urandom_range(0, 1));
            ready1 = 1'($urandom_range(0, 1));
            if (busy0) saw0 = 1'b1;
            if (busy1) saw1 = 1'b1;
            total++;
            if (freeze0 !== busy0) begin
                bad++; $display("FAIL freeze_en1 cyc%0d: got %b want %b", cyc, freeze0, busy0);
            end
            total++;
            if (freeze1 !== 1'b0) begin
                bad++; $display("FAIL freeze_en0 cyc%0d: got %b want 0", cyc, freeze1);
            end
        end
        start1 = 1'b0;
        total++;
        if (!(saw0 && saw1)) begin
            bad++; $display("FAIL freeze_activity: busy0 seen %b busy1 seen %b want 1/1", saw0, saw1);
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rf0[i] = '0;
            dm0[i] = '0;
        end
        for (int i = 0; i < 4; i++) rf1[i] = '0;
        test_reset();
        test_auto_dump();
        test_backpressure();
        test_small_manual();
        test_dropped_triggers();
        test_reset_mid_dump();
        test_freeze();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_state_dumper.md
Name: cpu_state_dumper

Overview:
- Synthesizable debug engine that captures a snapshot of architectural state from the pipeline CPU: the register file, then the data memory.
- It runs on a cycle-count trigger or an explicit start pulse, then streams one word per beat over a valid/ready interface.
- It sits beside Pipeline_CPU. It reads RF and DM through dedicated asynchronous read ports and can freeze the CPU so the snapshot is coherent.
- Generalises fixed-cycle register/memory printing: sizes, trigger cycle, freeze mode and back-pressure are all configurable.

Parameters:
- DATA_W, 32, width of register and memory words.
- NUM_REGS, 32, register entries dumped (indices 0..NUM_REGS-1); minimum 1.
- NUM_MEM, 32, memory words dumped (indices 0..NUM_MEM-1); 0 skips the memory phase.
- IDX_W, 8, width of the index and address outputs; must satisfy 2^IDX_W >= max(NUM_REGS, NUM_MEM).
- TRIG_CYCLE, 30, cycle count that fires the auto-trigger; 0 disables the auto-trigger.
- CNT_W, 16, cycle counter width.
- FREEZE_EN, 1, when 1, freeze_o is asserted while the block is busy.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  manual trigger pulse.
- rf_addr_o  out  IDX_W  register-file read address.
- rf_data_i  in  DATA_W  register-file read data, combinational from rf_addr_o.
- mem_addr_o  out  IDX_W  data-memory word read address.
- mem_data_i  in  DATA_W  data-memory read data, combinational from mem_addr_o.
- dump_valid_o  out  1  output beat valid.
- dump_ready_i  in  1  sink ready.
- dump_data_o  out  DATA_W  beat payload.
- dump_src_o  out  1  payload source: 0 = register, 1 = memory.
- dump_idx_o  out  IDX_W  index of the payload.
- dump_last_o  out  1  final beat of the snapshot.
- busy_o  out  1  snapshot in progress.
- freeze_o  out  1  stall request to the CPU.
- done_o  out  1  one-cycle pulse after the last beat is accepted.
- cycle_cnt_o  out  CNT_W  cycles since reset release; saturates at all-ones.

Behaviour:
- Single clock. Reset is synchronous and active-high.
- While rst_i is high, or on the first edge it is sampled high:
  - state goes to IDLE; cycle_cnt_o, dump_valid_o, dump_data_o, dump_src_o, dump_idx_o, dump_last_o, busy_o, freeze_o, done_o, rf_addr_o and mem_addr_o all go to 0;
  - the auto-trigger is re-armed.
- Reset mid-dump aborts immediately. No done_o is produced and partial beats are discarded.
- Cycle counter: increments by 1 on every clock with rst_i low; holds at 2^CNT_W-1.
- Trigger:
  - A trigger is start_i, or (armed and cycle_cnt_o == TRIG_CYCLE-1 and TRIG_CYCLE != 0), i.e. it fires on the TRIG_CYCLE-th clock edge.
  - The auto-trigger fires once per reset, then disarms.
  - Triggers that arrive while not in IDLE are dropped. There is no queueing.
- States:
  - IDLE: on a trigger, go to REG with idx=0 and busy_o=1.
  - REG: address output rf_addr_o = idx. The output stage loads when dump_valid_o==0 or dump_ready_i==1. A load captures rf_data_i, src=0 and idx, and sets valid=1, then increments idx. After loading idx NUM_REGS-1, go to MEM with idx=0, or go to DRAIN if NUM_MEM==0.
  - MEM: same as REG using mem_addr_o/mem_data_i with src=1. After loading idx NUM_MEM-1, go to DRAIN.
  - DRAIN: no new loads. When dump_valid_o && dump_ready_i, clear valid, pulse done_o, drop busy_o and return to IDLE.
- dump_last_o is 1 on the beat for the final index of the final non-empty phase.
- Latency: the first beat becomes valid 1 cycle after the trigger edge.
- Throughput: 1 beat per cycle with ready held high. A snapshot then takes NUM_REGS+NUM_MEM+1 cycles from trigger to done_o.
- Back-pressure: while valid && !ready, data/src/idx/last stay stable and idx does not advance.
- freeze_o = busy_o when FREEZE_EN=1, else 0. It asserts on the cycle after the trigger edge.
- Address outputs are 0 in IDLE and in DRAIN.
- Index arithmetic is unsigned IDX_W; it never wraps because the state changes at the terminal count.

Decomposition:
- Shared package: the state enum (IDLE, REG, MEM, DRAIN) and the source-code constants SRC_REG=0 and SRC_MEM=1.
- One natural sub-module: dump_out_stage. It is the single-entry valid/ready output register with load/hold logic and is reusable by other debug streamers.
- The trigger/counter and the FSM stay in the top level.

Test Plan:
- Auto dump, ready=1, RF[i]=i*3, DM[i]=100+i, defaults: 64 beats in order. Beat 0 is src0/idx0/data0 at cycle 30+1. Beat 63 is src1/idx31/data131 with last=1. done_o pulses exactly once, at cycle 30+65.
- Random back-pressure (ready 50%): each beat holds stable while stalled. No beat is lost or duplicated, and the total is still 64.
- NUM_MEM=0, NUM_REGS=4, start_i at cycle 5: exactly 4 src0 beats, last on idx3, and no mem_addr_o activity.
- start_i pulsed during busy, and auto-trigger cycle reached during busy: no second snapshot; after done_o, busy_o stays 0.
- rst_i asserted at beat 10: the next cycle shows all outputs 0. After release, the counter restarts and the auto-trigger fires again TRIG_CYCLE edges later.
- FREEZE_EN=0 vs 1: freeze_o stays 0 throughout when FREEZE_EN=0, and equals busy_o on every cycle when FREEZE_EN=1.
